// File: rtl/subtree_dispatch.sv
// Distributes parent command beats to one child lane (unicast) or all lanes (broadcast),
// keeping a saturating per-child delivery counter readable by index.
module subtree_dispatch #(
  parameter int N_CHILD = 5,
  parameter int DW      = 32,
  parameter int IDW     = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDW-1:0]     in_dest,
  input  logic [DW-1:0]      in_data,
  output logic [N_CHILD-1:0] out_valid,
  input  logic [N_CHILD-1:0] out_ready,
  output logic [DW-1:0]      out_data,
  output logic               busy,
  output logic               err_pulse,
  input  logic [IDW-1:0]     cnt_sel,
  output logic [CNT_W-1:0]   cnt_value
);

  if (N_CHILD < 1 || N_CHILD > (2**IDW) - 1) begin : g_bad_n_child
    $error("subtree_dispatch: N_CHILD must be in 1..2**IDW-1");
  end

  typedef enum logic [1:0] {IDLE, UNI, BCAST, ERR} state_t;

  localparam logic [IDW-1:0] BCAST_ID = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t             state, state_nxt;
  logic [N_CHILD-1:0] mask_nxt;
  logic [DW-1:0]      data_nxt;
  logic               err_nxt;
  logic [N_CHILD-1:0] done;
  logic [CNT_W-1:0]   cnt [N_CHILD];

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = out_valid & out_ready;

  // out_valid doubles as the pending mask: one-hot for unicast, all ones for broadcast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= '0;
      out_data  <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= mask_nxt;
      out_data  <= data_nxt;
      err_pulse <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = out_valid;
    data_nxt  = out_data;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt = in_data;
          if (in_dest < IDW'(N_CHILD)) begin
            state_nxt = UNI;
            mask_nxt  = N_CHILD'(1) << in_dest;
          end else if (in_dest == BCAST_ID) begin
            state_nxt = BCAST;
            mask_nxt  = '1;
          end else begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
          end
        end
      end
      UNI, BCAST: begin
        mask_nxt = out_valid & ~out_ready;
        if (mask_nxt == '0) state_nxt = IDLE;
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CHILD; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CHILD; i++)
        if (done[i]) cnt[i] <= sat_inc(cnt[i]);
    end
  end

  always_comb begin
    cnt_value = '0;
    for (int i = 0; i < N_CHILD; i++)
      if (cnt_sel == IDW'(i)) cnt_value = cnt[i];
  end

endmodule
